// File: rtl/secuenciador_inicializacion_if.sv
// Bundle of the sequencer control and status signals.
// Control side: tick/start are single-cycle strobes sampled on the rising
// edge and need no acknowledge. hold is a level. Status side: step_stb is a
// one-cycle "valid" for the step/pass_cnt values presented alongside it.
// There is no back-pressure: the consumer must take every step_stb.
interface secuenciador_inicializacion_if #(
  parameter int SW = 3,
  parameter int PW = 1
);
  logic          tick;
  logic          start;
  logic          hold;
  logic [SW-1:0] step;
  logic [PW-1:0] pass_cnt;
  logic          step_stb;
  logic          busy;
  logic          en;
  logic [1:0]    state_dbg;

  modport master (
    output tick, start, hold,
    input  step, pass_cnt, step_stb, busy, en, state_dbg
  );

  modport slave (
    input  tick, start, hold,
    output step, pass_cnt, step_stb, busy, en, state_dbg
  );
endinterface

// File: rtl/secuenciador_inicializacion.sv
// Initialisation sequencer: walks STEPS steps for PASSES passes, advancing on
// prescaler ticks, with an optional idle gap between passes. Raises en once
// the whole sequence has completed. All outputs are registered.
module secuenciador_inicializacion #(
  parameter int STEPS      = 5,
  parameter int PASSES     = 2,
  parameter int GAP_TICKS  = 0,
  parameter int AUTO_START = 1
) (
  input  logic clk,
  input  logic rst,
  secuenciador_inicializacion_if.slave bus
);

  localparam int SW = (STEPS  > 1) ? $clog2(STEPS)  : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  // The gap counter only needs to reach GAP_TICKS-1 before the final tick.
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);
  localparam bit            HAS_GAP   = (GAP_TICKS > 0);
  localparam logic [GW-1:0] GAP_LAST  = HAS_GAP ? GW'(GAP_TICKS - 1) : '0;
  localparam bit            AUTO      = (AUTO_START != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [SW-1:0] step_q;
  logic [PW-1:0] pass_q;
  logic [GW-1:0] gap_q;
  logic          stb_q;
  logic          busy_q;
  logic          en_q;

  // A tick only counts when nothing else claims the cycle; start has priority.
  logic tick_acc;
  assign tick_acc = bus.tick & ~bus.hold & ~bus.start;

  // Sequencer FSM; every output is produced here as a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      pass_q  <= '0;
      gap_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (bus.start) begin
        // Restart from any state, even while hold is high; the tick is dropped.
        state_q <= S_RUN;
        step_q  <= '0;
        pass_q  <= '0;
        gap_q   <= '0;
        busy_q  <= 1'b1;
        en_q    <= 1'b0;
      end else if (!bus.hold) begin
        case (state_q)
          S_IDLE: begin
            if (AUTO) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
          S_RUN: begin
            if (tick_acc) begin
              stb_q <= 1'b1;
              if (step_q != STEP_LAST) begin
                step_q <= step_q + SW'(1);
              end else if (pass_q != PASS_LAST) begin
                step_q <= '0;
                pass_q <= pass_q + PW'(1);
                if (HAS_GAP) begin
                  state_q <= S_GAP;
                end
              end else begin
                // Final step of final pass: counters keep their last values.
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                en_q    <= 1'b1;
              end
            end
          end
          S_GAP: begin
            if (tick_acc) begin
              if (gap_q == GAP_LAST) begin
                gap_q   <= '0;
                state_q <= S_RUN;
              end else begin
                gap_q <= gap_q + GW'(1);
              end
            end
          end
          S_DONE: begin
            // Ticks are ignored; only start leaves this state.
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.step      = step_q;
  assign bus.pass_cnt  = pass_q;
  assign bus.step_stb  = stb_q;
  assign bus.busy      = busy_q;
  assign bus.en        = en_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_secuenciador_inicializacion.sv
// Bench for secuenciador_inicializacion. Two instances share one stimulus
// stream: inst a uses the defaults (5,2,0,1), inst b uses GAP_TICKS=3 and
// AUTO_START=0. A behavioural model tracks each instance as "number of
// completed steps" plus a remaining-gap count.
module tb_secuenciador_inicializacion;

  localparam int STEPS  = 5;
  localparam int PASSES = 2;
  localparam int TOTAL  = STEPS * PASSES;
  localparam int SW     = (STEPS  > 1) ? $clog2(STEPS)  : 1;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int W      = SW + PW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic tick  = 1'b0;
  logic start = 1'b0;
  logic hold  = 1'b0;

  secuenciador_inicializacion_if #(.SW(SW), .PW(PW)) if_a ();
  secuenciador_inicializacion_if #(.SW(SW), .PW(PW)) if_b ();

  assign if_a.tick  = tick;
  assign if_a.start = start;
  assign if_a.hold  = hold;
  assign if_b.tick  = tick;
  assign if_b.start = start;
  assign if_b.hold  = hold;

  secuenciador_inicializacion #(
    .STEPS(STEPS), .PASSES(PASSES), .GAP_TICKS(0), .AUTO_START(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );

  secuenciador_inicializacion #(
    .STEPS(STEPS), .PASSES(PASSES), .GAP_TICKS(3), .AUTO_START(0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_k[2];      // steps completed in the current sequence
  int m_gap[2];    // ticks still to be idled before the next pass
  bit m_run[2];    // busy (running a pass or idling a gap)
  bit m_done[2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit auto_of(input int i);
    return (i == 0);
  endfunction

  function automatic int exp_step(input int i);
    return m_done[i] ? STEPS - 1 : m_k[i] % STEPS;
  endfunction

  function automatic int exp_pass(input int i);
    return m_done[i] ? PASSES - 1 : m_k[i] / STEPS;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_k[i] = 0; m_gap[i] = 0; m_run[i] = 1'b0; m_done[i] = 1'b0;
    end
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  task automatic model_cycle(input int i, input bit t, input bit h, input bit s);
    logic [W-1:0] e;
    if (s) begin
      m_k[i] = 0; m_gap[i] = 0; m_run[i] = 1'b1; m_done[i] = 1'b0;
    end else if (!h) begin
      if (!m_run[i] && !m_done[i]) begin
        if (auto_of(i)) m_run[i] = 1'b1;
      end else if (m_run[i] && t) begin
        if (m_gap[i] > 0) begin
          m_gap[i]--;
        end else begin
          m_k[i]++;
          if (m_k[i] == TOTAL) begin
            m_run[i] = 1'b0; m_done[i] = 1'b1;
          end else if (m_k[i] % STEPS == 0) begin
            m_gap[i] = gap_of(i);
          end
          e = {SW'(exp_step(i)), PW'(exp_pass(i)), m_done[i]};
          if (i == 0) exp_q_a.push_back(e);
          else        exp_q_b.push_back(e);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit t, input bit h, input bit s);
    @(negedge clk);
    tick = t; hold = h; start = s;
    for (int i = 0; i < 2; i++) model_cycle(i, t, h, s);
    @(posedge clk);
    #1;
    tick = 1'b0; hold = 1'b0; start = 1'b0;
  endtask

  task automatic check_levels(input string tag);
    chk({tag, "_a_step"}, int'(if_a.step),     exp_step(0));
    chk({tag, "_a_pass"}, int'(if_a.pass_cnt), exp_pass(0));
    chk({tag, "_a_busy"}, int'(if_a.busy),     int'(m_run[0]));
    chk({tag, "_a_en"},   int'(if_a.en),       int'(m_done[0]));
    chk({tag, "_b_step"}, int'(if_b.step),     exp_step(1));
    chk({tag, "_b_pass"}, int'(if_b.pass_cnt), exp_pass(1));
    chk({tag, "_b_busy"}, int'(if_b.busy),     int'(m_run[1]));
    chk({tag, "_b_en"},   int'(if_b.en),       int'(m_done[1]));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (if_a.step_stb) begin
        if (exp_q_a.size() == 0) begin
          chk("stb_a_unexpected", 1, 0);
        end else begin
          chk("stb_a_data", int'({if_a.step, if_a.pass_cnt, if_a.en}), int'(exp_q_a.pop_front()));
        end
      end
      if (if_b.step_stb) begin
        if (exp_q_b.size() == 0) begin
          chk("stb_b_unexpected", 1, 0);
        end else begin
          chk("stb_b_data", int'({if_b.step, if_b.pass_cnt, if_b.en}), int'(exp_q_b.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    model_reset();
    #12;
    check_levels("reset");
    chk("reset_a_stb", int'(if_a.step_stb), 0);
    @(posedge clk);
    #3 rst = 1'b1;

    // Auto start on a, b waits for start.
    cycle(0, 0, 0);
    check_levels("auto");

    // Ten ticks spaced four cycles apart: a completes, b stays idle.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      check_levels("ten");
      for (int j = 0; j < 3; j++) cycle(0, 0, 0);
    end
    check_levels("ten_end");

    // Start both; hold across ticks 3-4 so a needs 12 ticks.
    cycle(0, 0, 1);
    check_levels("start1");
    for (int i = 1; i <= 12; i++) begin
      cycle(1, (i == 3 || i == 4), 0);
      check_levels("hold");
      cycle(0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      check_levels("hold_tail");
    end

    // Start with a simultaneous tick at step 3, pass 1.
    cycle(0, 0, 1);
    n = 0;
    while (m_k[0] < 8 && n < 50) begin
      cycle(1, 0, 0);
      n++;
    end
    chk("restart_reach", m_k[0], 8);
    check_levels("pre_restart");
    cycle(1, 0, 1);
    check_levels("restart");
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      check_levels("restart_run");
    end

    // Asynchronous reset mid-sequence at step 2.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check_levels("pre_arst");
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_levels("arst");
    chk("arst_a_stb", int'(if_a.step_stb), 0);
    chk("arst_b_stb", int'(if_b.step_stb), 0);
    rst = 1'b1;
    cycle(0, 0, 0);
    check_levels("arst_rel");
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      check_levels("arst_run");
    end

    // Randomised run to completion of both instances.
    cycle(0, 0, 1);
    n = 0;
    while (!(m_done[0] && m_done[1]) && n < 600) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 0);
      check_levels("rnd_done");
      n++;
    end
    chk("rnd_done_timeout", int'(m_done[0] && m_done[1]), 1);

    // Fully random traffic including restarts.
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 39) == 0));
      check_levels("rnd");
    end

    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("drain_a", exp_q_a.size(), 0);
    chk("drain_b", exp_q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secuenciador_inicializacion.md
SECUENCIADOR_INICIALIZACION -- requirements
Module: secuenciador_inicializacion

Interface
REQ-001 Parameter STEPS, default 5: steps per pass; legal range >= 2.
REQ-002 Parameter PASSES, default 2: passes before completion; legal range >= 1.
REQ-003 Parameter GAP_TICKS, default 0: ticks idled between passes; 0 means no gap.
REQ-004 Parameter AUTO_START, default 1: 1 starts a sequence automatically after reset release; 0 waits for start.
REQ-005 Derived widths SW = max(1, ceil(log2(STEPS))) and PW = max(1, ceil(log2(PASSES))) SHALL be localparams.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 tick  input  1  one-cycle advance strobe from the prescaler.
REQ-009 start  input  1  one-cycle request to (re)start the sequence from step 0, pass 0.
REQ-010 hold  input  1  level; while high, ticks are ignored and all counters freeze.
REQ-011 step  output  SW  current step index, 0..STEPS-1.
REQ-012 pass_cnt  output  PW  current pass index, 0..PASSES-1.
REQ-013 step_stb  output  1  one-cycle pulse for each accepted tick in RUN.
REQ-014 busy  output  1  high in RUN or GAP.
REQ-015 en  output  1  level; high in DONE (sequence complete, downstream may proceed).

Function
REQ-016 The block SHALL implement four states: IDLE, RUN, GAP, DONE. All outputs SHALL be registered.
REQ-017 Accepted tick = tick & ~hold & ~start; any other tick SHALL have no effect.
REQ-018 IDLE: with AUTO_START=1, go to RUN on the first rising edge after rst deasserts. With AUTO_START=0, go to RUN on start. Step and pass_cnt SHALL be 0 on entry to RUN.
REQ-019 RUN with accepted tick and step < STEPS-1: step += 1; step_stb = 1 for the following cycle.
REQ-020 RUN with accepted tick and step = STEPS-1 and pass_cnt < PASSES-1: step = 0 and pass_cnt += 1. Next state is GAP if GAP_TICKS > 0, else RUN. step_stb = 1.
REQ-021 RUN with accepted tick and step = STEPS-1 and pass_cnt = PASSES-1: go to DONE. step and pass_cnt hold their final values; step_stb = 1.
REQ-022 GAP: an internal counter SHALL count accepted ticks. After the GAP_TICKS-th accepted tick, go to RUN. step_stb SHALL stay 0 in GAP.
REQ-023 DONE: en = 1, busy = 0. Ticks are ignored. start returns to RUN with step = 0, pass_cnt = 0, and en = 0 on the next cycle.
REQ-024 start in RUN or GAP SHALL restart: RUN, step = 0, pass_cnt = 0, gap counter cleared, no step_stb.
REQ-025 start and tick in the same cycle: start SHALL win, and the tick is discarded.
REQ-026 hold asserted in any state SHALL freeze state and counters. start SHALL still be honoured while hold is high.
REQ-027 Counters SHALL never exceed their ranges; no wrap beyond STEPS-1, PASSES-1 or GAP_TICKS.
REQ-028 A single pass (PASSES = 1) SHALL go from RUN directly to DONE and SHALL never enter GAP.

Reset
REQ-029 On rst low, regardless of clk: state = IDLE, step = 0, pass_cnt = 0, gap counter = 0, step_stb = 0, busy = 0, en = 0.
REQ-030 rst asserted mid-sequence SHALL abort immediately with no pending step_stb. Behaviour after release SHALL follow REQ-018.

Verification
REQ-031 Defaults (5,2,0,1): release rst, apply 10 ticks spaced 4 cycles apart.
- step goes 0,1,2,3,4,0,1,2,3,4.
- pass_cnt goes 0 to 1 after tick 5.
- 10 step_stb pulses.
- en = 1 one cycle after tick 10; busy = 0 from then.
REQ-032 Defaults: hold high across ticks 3-4.
- step remains 2 and no step_stb during hold.
- Completion requires 2 extra ticks, 12 in total.
REQ-033 Defaults: start at step = 3, pass_cnt = 1, with a simultaneous tick.
- Next cycle: step = 0, pass_cnt = 0, no step_stb.
- 10 further ticks then reach en.
REQ-034 GAP_TICKS = 3: after tick 5, busy = 1 with step = 0 and pass_cnt = 1.
- Ticks 6-8 produce no step_stb.
- Tick 9 gives step = 1.
- en after 13 ticks total.
REQ-035 AUTO_START = 0: 5 ticks before start leave step = 0 and busy = 0. After start, the 10-tick sequence completes normally.
REQ-036 rst pulsed low between clock edges at step = 2: all outputs clear without waiting for a clock edge. After release the sequence restarts from step = 0.
